calc_keypad_scan: RTL and testbench
===================================

Name: calc_keypad_scan

Overview:
- Upstream stage of the calculator FSM: scans a 4x4 active-low matrix keypad, synchronizes and debounces it, and emits one ASCII key event per physical press.
- Output pair btn_valid/btn_char connects directly to the calculator FSM's key input.
- Produces exactly the FSM's key alphabet: '0'-'9', '+', '-', '*', '=', 'C', 8'h08 (backspace).

Parameters:
- SCAN_DIV, 50000, clock cycles each column is driven before its rows are sampled (1 ms at 50 MHz); minimum 4.
- DEBOUNCE_CNT, 20, consecutive identical full-matrix frames required to accept a press or a release; minimum 1.
- REPEAT_DELAY, 500, frames a key must be held before the first auto-repeat (KEYPAD_REPEAT_EN only).
- REPEAT_RATE, 100, frames between later auto-repeats (KEYPAD_REPEAT_EN only).

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous reset, active-high.
- row_in  input  4  keypad rows, active-low, asynchronous, externally pulled up.
- col_out  output  4  column drive, active-low, exactly one bit low at any time.
- btn_valid  output  1  one-cycle pulse per accepted key event.
- btn_char  output  8  ASCII code of the last event; stable between pulses.
- key_held  output  1  high from press acceptance until release acceptance.

Behaviour:
- Reset (rst high at a clk edge):
  - Column index = 0; col_out = 4'b1110.
  - Dwell counter, frame accumulators and debounce counter = 0.
  - FSM = S_IDLE; btn_valid = 0; btn_char = 8'h00; key_held = 0.
  - Synchronizer flops = 4'b1111.
  - Asserting rst mid-debounce or mid-hold abandons the event with no pulse.
- Synchronizer: row_in passes through a 2-flop synchronizer before any use.
- Column scan:
  - The dwell counter counts 0..SCAN_DIV-1.
  - On the cycle the count equals SCAN_DIV-1, the synchronized rows are sampled for the current column, then the column index advances mod 4 and col_out rotates.
- Frame:
  - One frame is 4 columns, i.e. 4*SCAN_DIV cycles.
  - Per frame the block accumulates key_count (number of low row bits, saturating at 2) and the code of the pressed key.
  - Frame is evaluated on the cycle column 3 is sampled.
  - Classification: "none" if key_count = 0, "single" if 1, "multi" if 2 or more.
- Key map (row r, column c), rows 0..3:
  - Row 0: '1' '2' '3' '+'
  - Row 1: '4' '5' '6' '-'
  - Row 2: '7' '8' '9' '*'
  - Row 3: 'C' '0' '=' 8'h08
- FSM (steps only at frame evaluation):
  - S_IDLE:
    - single: cand <= key, cnt <= 1, go to S_DEBOUNCE.
    - If DEBOUNCE_CNT = 1, accept immediately (same action as reaching the count in S_DEBOUNCE).
    - none or multi: stay in S_IDLE.
  - S_DEBOUNCE:
    - single with the same key: cnt++.
    - When cnt reaches DEBOUNCE_CNT: btn_char <= cand, pulse btn_valid, key_held <= 1, go to S_HELD.
    - Any other classification or a different key: go to S_IDLE, no pulse.
  - S_HELD:
    - none: cnt <= 1, go to S_RELEASE.
    - single or multi (including a second key or a changed key): stay in S_HELD, no event.
  - S_RELEASE:
    - none: cnt++; on reaching DEBOUNCE_CNT, key_held <= 0 and go to S_IDLE.
    - Any key: go back to S_HELD, no new event.
- Event timing:
  - btn_valid is high for exactly the one clk cycle after the accepting frame evaluation.
  - btn_char updates in that same cycle.
  - At most one event per press; no event is ever generated on release.
- Latency: from a key made stable at the pins to the pulse is at most (DEBOUNCE_CNT+1) frames + 3 clk.
- Counters: sized with $clog2 of their maximum value; the debounce counter saturates and never wraps.

Optional Feature:
- Macro: KEYPAD_REPEAT_EN.
- Defined:
  - In S_HELD, a frame counter runs while the same single key stays pressed.
  - At REPEAT_DELAY frames, emit a btn_valid pulse with the same btn_char; after that, emit one every REPEAT_RATE frames.
  - Applies only to digits and 8'h08. 'C', '=', '+', '-', '*' never repeat.
  - The counter clears on leaving S_HELD or on a multi/changed frame.
- Undefined: no repeat logic is synthesized; exactly one pulse per press.

Test Plan:
- Bench parameters: SCAN_DIV=4, DEBOUNCE_CNT=3, so 1 frame = 16 clk.
1. Reset -> col_out=4'b1110, btn_valid=0, btn_char=8'h00, key_held=0; col_out rotates 1110->1101->1011->0111 every 4 clk.
2. Hold key row 1/col 2 for 6 frames -> exactly one btn_valid pulse with btn_char="6" (8'h36), about 4 frames after press; key_held=1 until 3 empty frames after release; no pulse on release.
3. Bouncing key row 3/col 3: present 2 frames, absent 1, present 4 -> single pulse with btn_char=8'h08, only after the second run.
4. Keys "1" and "2" pressed together for 8 frames -> no pulse. Then "2" pressed alone first and "5" added while held -> one pulse "2" only.
5. Assert rst for 1 clk mid-debounce of "=" (cnt=2) -> no pulse; all outputs return to reset values; a fresh press of "=" is detected normally.
6. With KEYPAD_REPEAT_EN, REPEAT_DELAY=4, REPEAT_RATE=2, hold "7" for 12 frames -> pulses at acceptance, then +4, +6, +8 frames, all with btn_char=8'h37. Holding "C" the same way -> one pulse only.

Source files
------------

// File: rtl/calc_keypad_scan.sv
// rtl/calc_keypad_scan.sv - 4x4 active-low keypad scanner, debouncer and ASCII key event generator
// Optional auto-repeat of held digits/backspace is built when KEYPAD_REPEAT_EN is defined.
module calc_keypad_scan #(
    parameter int SCAN_DIV     = 50000,
    parameter int DEBOUNCE_CNT = 20,
    parameter int REPEAT_DELAY = 500,
    parameter int REPEAT_RATE  = 100
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] row_in,
    output logic [3:0] col_out,
    output logic       btn_valid,
    output logic [7:0] btn_char,
    output logic       key_held
);

    localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int CW = $clog2(DEBOUNCE_CNT + 1);
    localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] CNT_MAX    = CW'(DEBOUNCE_CNT);

    localparam logic [1:0] S_IDLE     = 2'd0;
    localparam logic [1:0] S_DEBOUNCE = 2'd1;
    localparam logic [1:0] S_HELD     = 2'd2;
    localparam logic [1:0] S_RELEASE  = 2'd3;

    logic [3:0]    row_s1_q, row_s1_d, row_s2_q, row_s2_d;
    logic [DW-1:0] dwell_q, dwell_d;
    logic [1:0]    col_idx_q, col_idx_d;
    logic [1:0]    kc_q, kc_d;
    logic [7:0]    code_q, code_d;
    logic [1:0]    state_q, state_d;
    logic [7:0]    cand_q, cand_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          btn_valid_q, btn_valid_d;
    logic [7:0]    btn_char_q, btn_char_d;
    logic          key_held_q, key_held_d;

    logic          frame_eval, hit, accept;
    logic [1:0]    hit_row, frame_kc;
    logic [2:0]    lows, sum;
    logic [7:0]    frame_code;
    logic          is_none, is_single;

`ifdef KEYPAD_REPEAT_EN
    localparam int REP_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int RW      = $clog2(REP_MAX + 1);
    logic [RW-1:0] rep_q, rep_d;
    logic          rep_first_q, rep_first_d;

    function automatic logic repeatable(input logic [7:0] c);
        return ((c >= 8'h30) && (c <= 8'h39)) || (c == 8'h08);
    endfunction
`else
    logic unused_repeat_params;
    assign unused_repeat_params = ^{REPEAT_DELAY, REPEAT_RATE};
`endif

    function automatic logic [7:0] key_map(input logic [1:0] r, input logic [1:0] c);
        case ({r, c})
            4'h0:    return 8'h31;
            4'h1:    return 8'h32;
            4'h2:    return 8'h33;
            4'h3:    return 8'h2B;
            4'h4:    return 8'h34;
            4'h5:    return 8'h35;
            4'h6:    return 8'h36;
            4'h7:    return 8'h2D;
            4'h8:    return 8'h37;
            4'h9:    return 8'h38;
            4'hA:    return 8'h39;
            4'hB:    return 8'h2A;
            4'hC:    return 8'h43;
            4'hD:    return 8'h30;
            4'hE:    return 8'h3D;
            default: return 8'h08;
        endcase
    endfunction

    always_comb begin
        row_s1_d    = row_in;
        row_s2_d    = row_s1_q;
        dwell_d     = dwell_q;
        col_idx_d   = col_idx_q;
        kc_d        = kc_q;
        code_d      = code_q;
        state_d     = state_q;
        cand_d      = cand_q;
        cnt_d       = cnt_q;
        btn_valid_d = 1'b0;
        btn_char_d  = btn_char_q;
        key_held_d  = key_held_q;
        frame_eval  = 1'b0;
        accept      = 1'b0;
        hit         = 1'b0;
        hit_row     = 2'd0;
        lows        = 3'd0;
        sum         = 3'd0;
        frame_kc    = 2'd0;
        frame_code  = code_q;
`ifdef KEYPAD_REPEAT_EN
        rep_d       = rep_q;
        rep_first_d = rep_first_q;
`endif

        for (int r = 3; r >= 0; r--) begin
            if (!row_s2_q[r]) begin
                hit     = 1'b1;
                hit_row = 2'(r);
            end
            lows = lows + {2'b00, ~row_s2_q[r]};
        end

        if (dwell_q == DWELL_LAST) begin
            dwell_d    = '0;
            col_idx_d  = col_idx_q + 2'd1;
            sum        = {1'b0, kc_q} + lows;
            frame_kc   = (sum >= 3'd2) ? 2'd2 : sum[1:0];
            if (hit)
                frame_code = key_map(hit_row, col_idx_q);
            // Column 3 closes the frame: hand the totals to the FSM and start fresh.
            if (col_idx_q == 2'd3) begin
                frame_eval = 1'b1;
                kc_d       = 2'd0;
                code_d     = 8'h00;
            end else begin
                kc_d   = frame_kc;
                code_d = frame_code;
            end
        end else begin
            dwell_d = dwell_q + 1'b1;
        end

        is_none   = (frame_kc == 2'd0);
        is_single = (frame_kc == 2'd1);

        if (frame_eval) begin
            case (state_q)
                S_IDLE: begin
                    if (is_single) begin
                        cand_d = frame_code;
                        cnt_d  = CW'(1);
                        if (DEBOUNCE_CNT == 1) accept  = 1'b1;
                        else                   state_d = S_DEBOUNCE;
                    end
                end
                S_DEBOUNCE: begin
                    if (is_single && (frame_code == cand_q)) begin
                        cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
                        if (cnt_d == CNT_MAX) accept = 1'b1;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
                S_HELD: begin
                    if (is_none) begin
                        cnt_d = CW'(1);
                        if (DEBOUNCE_CNT == 1) begin
                            key_held_d = 1'b0;
                            state_d    = S_IDLE;
                        end else begin
                            state_d = S_RELEASE;
                        end
`ifdef KEYPAD_REPEAT_EN
                        rep_d       = '0;
                        rep_first_d = 1'b0;
                    end else if (is_single && (frame_code == cand_q) && repeatable(cand_q)) begin
                        rep_d = rep_q + 1'b1;
                        if (rep_d == (rep_first_q ? RW'(REPEAT_RATE) : RW'(REPEAT_DELAY))) begin
                            btn_valid_d = 1'b1;
                            rep_d       = '0;
                            rep_first_d = 1'b1;
                        end
                    end else begin
                        rep_d       = '0;
                        rep_first_d = 1'b0;
`endif
                    end
                end
                default: begin
                    if (is_none) begin
                        cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
                        if (cnt_d == CNT_MAX) begin
                            key_held_d = 1'b0;
                            state_d    = S_IDLE;
                        end
                    end else begin
                        state_d = S_HELD;
                    end
                end
            endcase

            if (accept) begin
                btn_char_d  = cand_d;
                btn_valid_d = 1'b1;
                key_held_d  = 1'b1;
                state_d     = S_HELD;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            row_s1_q    <= 4'b1111;
            row_s2_q    <= 4'b1111;
            dwell_q     <= '0;
            col_idx_q   <= 2'd0;
            kc_q        <= 2'd0;
            code_q      <= 8'h00;
            state_q     <= S_IDLE;
            cand_q      <= 8'h00;
            cnt_q       <= '0;
            btn_valid_q <= 1'b0;
            btn_char_q  <= 8'h00;
            key_held_q  <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
            rep_q       <= '0;
            rep_first_q <= 1'b0;
`endif
        end else begin
            row_s1_q    <= row_s1_d;
            row_s2_q    <= row_s2_d;
            dwell_q     <= dwell_d;
            col_idx_q   <= col_idx_d;
            kc_q        <= kc_d;
            code_q      <= code_d;
            state_q     <= state_d;
            cand_q      <= cand_d;
            cnt_q       <= cnt_d;
            btn_valid_q <= btn_valid_d;
            btn_char_q  <= btn_char_d;
            key_held_q  <= key_held_d;
`ifdef KEYPAD_REPEAT_EN
            rep_q       <= rep_d;
            rep_first_q <= rep_first_d;
`endif
        end
    end

    assign col_out   = ~(4'b0001 << col_idx_q);
    assign btn_valid = btn_valid_q;
    assign btn_char  = btn_char_q;
    assign key_held  = key_held_q;

endmodule

// File: tb/tb_calc_keypad_scan.sv
// tb/tb_calc_keypad_scan.sv - directed bench for calc_keypad_scan (SCAN_DIV=4, DEBOUNCE_CNT=3, 16 clk per frame)
module tb_calc_keypad_scan;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] row_in;
    logic [3:0] col_out;
    logic       btn_valid;
    logic [7:0] btn_char;
    logic       key_held;

    logic [15:0] key_mask = 16'h0000;
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          pulses = 0;
    int          last_pulse = -1;
    int          wide = 0;
    logic [7:0]  last_char = 8'h00;
    logic        prev_valid = 1'b0;

    calc_keypad_scan #(
        .SCAN_DIV(4), .DEBOUNCE_CNT(3), .REPEAT_DELAY(4), .REPEAT_RATE(2)
    ) dut (
        .clk(clk), .rst(rst), .row_in(row_in), .col_out(col_out),
        .btn_valid(btn_valid), .btn_char(btn_char), .key_held(key_held)
    );

    always #5 clk = ~clk;

    // Matrix model: key (r,c) pulls row r low while column c is driven low.
    always_comb begin
        for (int r = 0; r < 4; r++)
            row_in[r] = ~|(key_mask[r*4 +: 4] & ~col_out);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h (cyc %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic step();
        @(negedge clk);
        cyc++;
        if (btn_valid) begin
            pulses++;
            last_pulse = cyc;
            last_char  = btn_char;
            if (prev_valid) wide++;
        end
        prev_valid = btn_valid;
    endtask

    task automatic run_to(input int target);
        while (cyc < target) step();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        cyc = 0; pulses = 0; last_pulse = -1; prev_valid = 1'b0;
    endtask

    initial begin
        // 1: reset values and column rotation
        do_reset();
        check("rst_col", col_out, 4'b1110);
        check("rst_valid", btn_valid, 1'b0);
        check("rst_char", btn_char, 8'h00);
        check("rst_held", key_held, 1'b0);
        run_to(4);  check("rot_c1", col_out, 4'b1101);
        run_to(8);  check("rot_c2", col_out, 4'b1011);
        run_to(12); check("rot_c3", col_out, 4'b0111);
        run_to(16); check("rot_wrap", col_out, 4'b1110);

        // 2: '6' held 6 frames, accepted after the third frame, release after 3 empty frames
        do_reset();
        key_mask = 16'h0040;
        run_to(47); check("k6_held_pre", key_held, 1'b0);
        check("k6_char_pre", btn_char, 8'h00);
        run_to(48); check("k6_held", key_held, 1'b1);
        run_to(96);
        check("k6_pulses", pulses, 1);
        check("k6_char", last_char, 8'h36);
        check("k6_when", last_pulse, 48);
        key_mask = 16'h0000;
        run_to(143); check("k6_held_rel", key_held, 1'b1);
        run_to(144); check("k6_released", key_held, 1'b0);
        run_to(200); check("k6_no_rel_pulse", pulses, 1);

        // 3: bouncing backspace 2 on / 1 off / 4 on
        do_reset();
        key_mask = 16'h8000;
        run_to(32); key_mask = 16'h0000;
        run_to(48); check("bs_bounce_none", pulses, 0);
        key_mask = 16'h8000;
        run_to(112); key_mask = 16'h0000;
        run_to(200);
        check("bs_pulses", pulses, 1);
        check("bs_char", last_char, 8'h08);
        check("bs_when", last_pulse, 96);

        // 4: two keys together ignored; second key added while held ignored
        do_reset();
        key_mask = 16'h0003;
        run_to(128);
        check("multi_none", pulses, 0);
        check("multi_held", key_held, 1'b0);
        key_mask = 16'h0000;
        run_to(144); key_mask = 16'h0002;
        run_to(208); key_mask = 16'h0022;
        run_to(272); check("k2_held", key_held, 1'b1);
        key_mask = 16'h0000;
        run_to(400);
        check("k2_pulses", pulses, 1);
        check("k2_char", last_char, 8'h32);
        check("k2_when", last_pulse, 192);
        check("k2_released", key_held, 1'b0);

        // 5: reset mid-debounce of '=' abandons the event
        do_reset();
        key_mask = 16'h4000;
        run_to(40);
        check("eq_pre_rst", pulses, 0);
        do_reset();
        check("eq_rst_col", col_out, 4'b1110);
        check("eq_rst_held", key_held, 1'b0);
        check("eq_rst_char", btn_char, 8'h00);
        check("eq_rst_valid", btn_valid, 1'b0);
        run_to(64);
        check("eq_pulses", pulses, 1);
        check("eq_char", last_char, 8'h3D);
        check("eq_when", last_pulse, 48);
        key_mask = 16'h0000;
        run_to(120);

`ifdef KEYPAD_REPEAT_EN
        // 6: '7' repeats at +4, +6, +8 frames; 'C' never repeats
        do_reset();
        key_mask = 16'h0100;
        run_to(192); key_mask = 16'h0000;
        run_to(260);
        check("rep7_pulses", pulses, 4);
        check("rep7_char", last_char, 8'h37);
        check("rep7_last", last_pulse, 176);
        do_reset();
        key_mask = 16'h1000;
        run_to(192); key_mask = 16'h0000;
        run_to(260);
        check("repC_pulses", pulses, 1);
        check("repC_char", last_char, 8'h43);
`endif

        check("pulse_width", wide, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
